// File: rtl/whack_hit_judge.sv
// rtl/whack_hit_judge.sv - debounced whack-a-mole hit/miss judge with score and best tracking
// Optional MISS_PENALTY_EN: misses (including timeouts) decrement the score, saturating at 0.
module whack_hit_judge #(
    parameter int DEBOUNCE_CYCLES    = 500000,
    parameter int MOLE_WINDOW_CYCLES = 50000000,
    parameter int SCORE_W            = 8
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [3:0]         keys_n,
    input  logic [2:0]         state,
    output logic               hit,
    output logic               miss,
    output logic               mole_done,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] best,
    output logic [3:0]         keys_db
);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int WIN_W = $clog2(MOLE_WINDOW_CYCLES) + 1;
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(MOLE_WINDOW_CYCLES - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ARMED, RESOLVE, WAIT_LEAVE} judge_t;

    logic [3:0]         sync1_q, sync2_q;
    logic [3:0]         keys_db_q, keys_db_d, db_prev_q;
    logic [DB_W-1:0]    db_cnt_q [4];
    logic [DB_W-1:0]    db_cnt_d [4];
    logic [3:0]         key_lvl, press_edge;
    judge_t             st_q, st_d;
    logic [1:0]         exp_q, exp_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic               res_hit_q, res_hit_d;
    logic [SCORE_W-1:0] score_q, score_d, best_q, best_d;
    logic [2:0]         prev_state_q;
    logic               is_mole;
    logic [1:0]         mole_idx;

    assign key_lvl    = ~sync2_q;
    assign press_edge = keys_db_q & ~db_prev_q;
    assign is_mole    = (state >= 3'd2) && (state <= 3'd5);
    // Codes 2..5 map onto key index 0..3 with a 2-bit wrap-around subtract.
    assign mole_idx   = state[1:0] - 2'd2;

    always_comb begin
        keys_db_d = keys_db_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (key_lvl[i] != keys_db_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    keys_db_d[i] = key_lvl[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        st_d      = st_q;
        exp_d     = exp_q;
        win_d     = win_q;
        res_hit_d = res_hit_q;
        case (st_q)
            IDLE: begin
                if (is_mole) begin
                    st_d  = ARMED;
                    exp_d = mole_idx;
                    win_d = '0;
                end
            end
            ARMED: begin
                win_d = win_q + 1'b1;
                if (press_edge == (4'b0001 << exp_q)) begin
                    st_d      = RESOLVE;
                    res_hit_d = 1'b1;
                end else if (press_edge != 4'b0000 || win_q == WIN_LAST) begin
                    st_d      = RESOLVE;
                    res_hit_d = 1'b0;
                end else if (!is_mole) begin
                    st_d = IDLE;
                end
            end
            RESOLVE: st_d = WAIT_LEAVE;
            WAIT_LEAVE: begin
                if (!is_mole) begin
                    st_d = IDLE;
                end else if (mole_idx != exp_q) begin
                    st_d  = ARMED;
                    exp_d = mole_idx;
                    win_d = '0;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_comb begin
        score_d = score_q;
        if (state == 3'd0) begin
            score_d = '0;
        end else if (st_q == RESOLVE) begin
            if (res_hit_q && score_q != SCORE_MAX) begin
                score_d = score_q + 1'b1;
            end
`ifdef MISS_PENALTY_EN
            if (!res_hit_q && score_q != '0) begin
                score_d = score_q - 1'b1;
            end
`else
`endif
        end
    end

    always_comb begin
        best_d = best_q;
        if (state == 3'd6 && prev_state_q != 3'd6 && score_q > best_q) begin
            best_d = score_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            sync1_q      <= 4'hF;
            sync2_q      <= 4'hF;
            keys_db_q    <= 4'h0;
            db_prev_q    <= 4'h0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            st_q         <= IDLE;
            exp_q        <= 2'd0;
            win_q        <= '0;
            res_hit_q    <= 1'b0;
            score_q      <= '0;
            best_q       <= '0;
            prev_state_q <= 3'd0;
        end else begin
            sync1_q      <= keys_n;
            sync2_q      <= sync1_q;
            keys_db_q    <= keys_db_d;
            db_prev_q    <= keys_db_q;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            st_q         <= st_d;
            exp_q        <= exp_d;
            win_q        <= win_d;
            res_hit_q    <= res_hit_d;
            score_q      <= score_d;
            best_q       <= best_d;
            prev_state_q <= state;
        end
    end

    assign hit       = (st_q == RESOLVE) && res_hit_q;
    assign miss      = (st_q == RESOLVE) && !res_hit_q;
    assign mole_done = (st_q == RESOLVE);
    assign score     = score_q;
    assign best      = best_q;
    assign keys_db   = keys_db_q;
endmodule

// File: tb/tb_whack_hit_judge.sv
// tb/tb_whack_hit_judge.sv - self-checking bench for whack_hit_judge
module tb_whack_hit_judge;
    logic       clock = 1'b0;
    logic       resetn;
    logic [3:0] keys_n;
    logic [2:0] state;
    logic       hit, miss, mole_done;
    logic [7:0] score, best;
    logic [3:0] keys_db;

    int checks = 0;
    int errors = 0;
    int hit_cnt = 0, miss_cnt = 0, done_cnt = 0;
    int exp_score = 0, exp_best = 0;

    typedef struct {
        logic [2:0] st;
        logic [3:0] mask;
        int         eh;
        int         em;
    } vec_t;
    vec_t vecs [10];

    whack_hit_judge #(
        .DEBOUNCE_CYCLES(4),
        .MOLE_WINDOW_CYCLES(20),
        .SCORE_W(8)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .keys_n(keys_n),
        .state(state),
        .hit(hit),
        .miss(miss),
        .mole_done(mole_done),
        .score(score),
        .best(best),
        .keys_db(keys_db)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (resetn) begin
            hit_cnt  += int'(hit);
            miss_cnt += int'(miss);
            done_cnt += int'(mole_done);
            if (hit || miss || mole_done) begin
                checks++;
                if (!(mole_done && (hit != miss))) begin
                    errors++;
                    $display("FAIL pulse_combo actual hit=%0b miss=%0b done=%0b required done with exactly one of hit/miss",
                             hit, miss, mole_done);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    // Score/best rules applied at the granularity of one mole appearance.
    task automatic model_apply(input logic [2:0] st, input int eh, input int em);
        if (st == 3'd0) exp_score = 0;
        if (st == 3'd6 && exp_score > exp_best) exp_best = exp_score;
        if (eh != 0 && exp_score < 255) exp_score = exp_score + 1;
`ifdef MISS_PENALTY_EN
        if (em != 0 && exp_score > 0) exp_score = exp_score - 1;
`else
        if (em != 0) exp_score = exp_score;
`endif
    endtask

    task automatic run_vec(input logic [2:0] st, input logic [3:0] mask);
        state = st;
        tick(2);
        if (mask != 4'h0) begin
            keys_n = ~mask;
            tick(8);
            keys_n = 4'hF;
            tick(20);
        end else begin
            tick(28);
        end
        state = 3'd1;
        tick(10);
    endtask

    task automatic do_vec(input string name, input logic [2:0] st, input logic [3:0] mask,
                          input int eh, input int em);
        int h0, m0, d0;
        h0 = hit_cnt; m0 = miss_cnt; d0 = done_cnt;
        run_vec(st, mask);
        model_apply(st, eh, em);
        check({name, "_hits"}, hit_cnt - h0, eh);
        check({name, "_misses"}, miss_cnt - m0, em);
        check({name, "_done"}, done_cnt - d0, eh + em);
        check({name, "_score"}, int'(score), exp_score);
        check({name, "_best"}, int'(best), exp_best);
    endtask

    task automatic play_game(input int n);
        run_vec(3'd0, 4'h0);
        model_apply(3'd0, 0, 0);
        for (int i = 0; i < n; i++) begin
            run_vec(3'd2, 4'b0001);
            model_apply(3'd2, 1, 0);
        end
        run_vec(3'd6, 4'h0);
        model_apply(3'd6, 0, 0);
    endtask

    initial begin
        int s0, h0, m0;
        vecs[0] = '{3'd3, 4'b0010, 1, 0};
        vecs[1] = '{3'd4, 4'b0000, 0, 1};
        vecs[2] = '{3'd2, 4'b1001, 0, 1};
        vecs[3] = '{3'd5, 4'b1000, 1, 0};
        vecs[4] = '{3'd2, 4'b0100, 0, 1};
        vecs[5] = '{3'd1, 4'b0001, 0, 0};
        vecs[6] = '{3'd6, 4'b0010, 0, 0};
        vecs[7] = '{3'd0, 4'b0100, 0, 0};
        vecs[8] = '{3'd4, 4'b0100, 1, 0};
        vecs[9] = '{3'd3, 4'b0001, 0, 1};

        // Reset with all keys held and a mole showing.
        resetn = 1'b0; keys_n = 4'h0; state = 3'd2;
        tick(2);
        check("rst_hit", int'(hit), 0);
        check("rst_miss", int'(miss), 0);
        check("rst_done", int'(mole_done), 0);
        check("rst_score", int'(score), 0);
        check("rst_best", int'(best), 0);
        check("rst_keys_db", int'(keys_db), 0);
        resetn = 1'b1;
        tick(4);
        check("post_rst_db_low", int'(keys_db), 0);
        check("post_rst_no_miss", miss_cnt, 0);
        tick(2);
        check("post_rst_db_high", int'(keys_db), 15);
        tick(1);
        check("post_rst_multi_miss", int'(miss), 1);
        model_apply(3'd2, 0, 1);
        keys_n = 4'hF; state = 3'd1;
        tick(12);

        // Exact debounce and pulse latency on Mole2.
        state = 3'd3;
        tick(2);
        keys_n = 4'b1101;
        tick(5);
        check("lat_db_not_yet", int'(keys_db[1]), 0);
        tick(1);
        check("lat_db_rise", int'(keys_db[1]), 1);
        check("lat_hit_not_yet", int'(hit), 0);
        s0 = int'(score);
        tick(1);
        check("lat_hit", int'(hit), 1);
        check("lat_done", int'(mole_done), 1);
        check("lat_score_hold", int'(score), s0);
        tick(1);
        check("lat_hit_drop", int'(hit), 0);
        model_apply(3'd3, 1, 0);
        check("lat_score_inc", int'(score), exp_score);
        keys_n = 4'hF; tick(20); state = 3'd1; tick(10);

        // Bounce then settle gives one edge.
        h0 = hit_cnt; m0 = miss_cnt;
        state = 3'd3; tick(2);
        keys_n = 4'b1101; tick(2);
        keys_n = 4'hF;    tick(2);
        keys_n = 4'b1101; tick(12);
        check("bounce_hits", hit_cnt - h0, 1);
        check("bounce_misses", miss_cnt - m0, 0);
        model_apply(3'd3, 1, 0);
        keys_n = 4'hF; tick(10); state = 3'd1; tick(10);

        // Timeout exactly 21 cycles after entry.
        state = 3'd4;
        tick(20);
        check("to_not_yet", int'(miss), 0);
        tick(1);
        check("to_miss", int'(miss), 1);
        check("to_done", int'(mole_done), 1);
        tick(1);
        check("to_drop", int'(miss), 0);
        model_apply(3'd4, 0, 1);
        check("to_score", int'(score), exp_score);
        state = 3'd1; tick(10);

        // Multi-key miss, keys ignored in WAIT_LEAVE, re-arm via Game and directly.
        h0 = hit_cnt; m0 = miss_cnt;
        state = 3'd2; tick(2);
        keys_n = 4'b0110; tick(8); keys_n = 4'hF; tick(8);
        check("multi_miss", miss_cnt - m0, 1);
        keys_n = 4'b1110; tick(8); keys_n = 4'hF; tick(10);
        check("wl_ignore_hits", hit_cnt - h0, 0);
        check("wl_ignore_misses", miss_cnt - m0, 1);
        model_apply(3'd2, 0, 1);
        state = 3'd1; tick(2);
        state = 3'd5; tick(2);
        keys_n = 4'b0111; tick(8); keys_n = 4'hF; tick(10);
        check("rearm_hit", hit_cnt - h0, 1);
        model_apply(3'd5, 1, 0);
        state = 3'd2; tick(2);
        keys_n = 4'b1110; tick(8); keys_n = 4'hF; tick(10);
        check("direct_rearm_hit", hit_cnt - h0, 2);
        model_apply(3'd2, 1, 0);
        state = 3'd1; tick(10);
        check("rearm_score", int'(score), exp_score);

        // Correct edge on the timeout cycle counts as a hit.
        state = 3'd2;
        tick(14);
        keys_n = 4'b1110;
        tick(6);
        check("edge_to_no_pulse", int'(hit | miss), 0);
        tick(1);
        check("edge_to_hit", int'(hit), 1);
        check("edge_to_not_miss", int'(miss), 0);
        model_apply(3'd2, 1, 0);
        keys_n = 4'hF; tick(10); state = 3'd1; tick(10);

        // Leaving mid-window abandons the mole.
        h0 = hit_cnt; m0 = miss_cnt;
        state = 3'd2; tick(5); state = 3'd1; tick(30);
        check("leave_hits", hit_cnt - h0, 0);
        check("leave_misses", miss_cnt - m0, 0);
        do_vec("leave_rearm", 3'd2, 4'b0001, 1, 0);

        for (int i = 0; i < 10; i++) begin
            do_vec($sformatf("vec%0d", i), vecs[i].st, vecs[i].mask, vecs[i].eh, vecs[i].em);
        end

        // Random moles against the rule-level model.
        for (int i = 0; i < 40; i++) begin
            int m, act, other, eh, em;
            logic [3:0] mask;
            m = int'($urandom_range(3, 0));
            act = int'($urandom_range(4, 0));
            other = (m + 1 + int'($urandom_range(2, 0))) % 4;
            eh = 0; em = 0; mask = 4'h0;
            case (act)
                0: begin mask = 4'(1 << m); eh = 1; end
                1: begin mask = 4'(1 << other); em = 1; end
                2: begin mask = 4'((1 << m) | (1 << other)); em = 1; end
                3: em = 1;
                default: ;
            endcase
            if (act == 4) begin
                h0 = hit_cnt; m0 = miss_cnt;
                state = 3'(m + 2); tick(3); state = 3'd1; tick(37);
                check($sformatf("rnd%0d_leave", i), (hit_cnt - h0) + (miss_cnt - m0), 0);
            end else begin
                do_vec($sformatf("rnd%0d", i), 3'(m + 2), mask, eh, em);
            end
            if ($urandom_range(9, 0) == 0) do_vec($sformatf("rnd%0d_clr", i), 3'd0, 4'h0, 0, 0);
        end

        // Best across games.
        play_game(3);
        play_game(7);
        check("best_after_7", int'(best), exp_best);
        play_game(2);
        check("best_hold", int'(best), exp_best);
        check("score_2", int'(score), 2);
        state = 3'd0; tick(2);
        check("start_clear", int'(score), 0);
        model_apply(3'd0, 0, 0);
        state = 3'd1; tick(2);

        // Saturation at 255.
        for (int i = 0; i < 256; i++) begin
            run_vec(3'd2, 4'b0001);
            model_apply(3'd2, 1, 0);
        end
        check("sat_score", int'(score), 255);
        check("sat_model", int'(score), exp_score);
        do_vec("sat_gameover", 3'd6, 4'h0, 0, 0);
        check("sat_best", int'(best), 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
